// File: rtl/mul_err_pkg.sv
// Shared types and helpers for the approximate-multiplier error accumulator.
// Saturating adders work on 64-bit containers clamped to a runtime width.
package mul_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IN_W_D   = 8;
  localparam int PROD_W_D = 16;
  localparam int ACC_W_D  = 32;

  function automatic logic [63:0] sat_add_u(
    input logic [63:0] acc,
    input logic [63:0] inc,
    input int unsigned w
  );
    logic [63:0] max_v;
    logic [63:0] sum;
    max_v = (64'd1 << w) - 64'd1;
    sum   = acc + inc;
    return (sum > max_v) ? max_v : sum;
  endfunction

  function automatic logic signed [63:0] sat_add_s(
    input logic signed [63:0] acc,
    input logic signed [63:0] inc,
    input int unsigned        w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] sum;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    sum = acc + inc;
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/mul_err_diff.sv
// Stage 2: signed error, magnitude and mismatch flag of one sample.
// Data registers only load on valid so idle cycles hold stable values.
module mul_err_diff
  import mul_err_pkg::*;
#(
  parameter int PROD_W = PROD_W_D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_valid,
  input  logic [PROD_W-1:0]        i_exact,
  input  logic [PROD_W-1:0]        i_apprx,
  output logic                     o_valid,
  output logic signed [PROD_W:0]   o_diff,
  output logic [PROD_W-1:0]        o_absd,
  output logic                     o_neq
);

  logic signed [PROD_W:0] w_diff;
  logic [PROD_W-1:0]      w_mag;
  logic                   r_valid;
  logic signed [PROD_W:0] r_diff;
  logic [PROD_W-1:0]      r_absd;
  logic                   r_neq;

  assign w_diff = $signed({1'b0, i_exact})
                - $signed({1'b0, i_apprx});
  // |diff| never exceeds 2^PROD_W-1, so truncation is lossless
  assign w_mag  = PROD_W'($unsigned(
                    w_diff[PROD_W] ? -w_diff : w_diff));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_diff  <= '0;
      r_absd  <= '0;
      r_neq   <= 1'b0;
    end else begin
      r_valid <= i_clr ? 1'b0 : i_valid;
      if (i_valid) begin
        r_diff <= w_diff;
        r_absd <= w_mag;
        r_neq  <= |w_diff;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_diff  = r_diff;
  assign o_absd  = r_absd;
  assign o_neq   = r_neq;

endmodule

// File: rtl/mul8_err_accumulator.sv
// Error-metric accumulator behind an approximate 8-bit multiplier.
// Two-stage pipeline feeding saturating accumulators; run length N_SAMPLES.
module mul8_err_accumulator
  import mul_err_pkg::*;
#(
  parameter int IN_W      = IN_W_D,
  parameter int PROD_W    = PROD_W_D,
  parameter int N_SAMPLES = 10000,
  parameter int ACC_W     = ACC_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   a,
  input  logic [IN_W-1:0]   b,
  input  logic [PROD_W-1:0] apprx,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sample_cnt,
  output logic [ACC_W-1:0]  err_cnt,
  output logic [ACC_W-1:0]  sum_ed,
  output logic [ACC_W-1:0]  sum_aed,
  output logic [PROD_W-1:0] max_aed
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_clr;
  logic w_acc;
  logic w_last;

  logic [ACC_W-1:0]  r_cnt;
  logic              r_v1;
  logic [PROD_W-1:0] r_exact;
  logic [PROD_W-1:0] r_apprx;

  logic                   w_v2;
  logic signed [PROD_W:0] w_diff;
  logic [PROD_W-1:0]      w_absd;
  logic                   w_neq;

  logic [ACC_W-1:0]  r_err;
  logic [ACC_W-1:0]  r_sed;
  logic [ACC_W-1:0]  r_saed;
  logic [PROD_W-1:0] r_max;

  assign w_clr  = start && (r_state == IDLE || r_state == DONE);
  assign w_acc  = in_valid && in_ready;
  assign w_last = w_acc
               && (r_cnt == ACC_W'(N_SAMPLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // DRAIN exits once stage 1 is empty: stage 2 retires on that same edge
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (start)  w_state_nxt = RUN;
      RUN:   if (w_last) w_state_nxt = DRAIN;
      DRAIN: if (!r_v1)  w_state_nxt = DONE;
      DONE:  if (start)  w_state_nxt = RUN;
      default:           w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == RUN)
            && (r_cnt < ACC_W'(N_SAMPLES));
    busy     = (r_state == RUN) || (r_state == DRAIN);
    done     = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_v1    <= 1'b0;
      r_exact <= '0;
      r_apprx <= '0;
    end else begin
      if (w_clr)      r_cnt <= '0;
      else if (w_acc) r_cnt <= r_cnt + ACC_W'(1);
      r_v1 <= w_clr ? 1'b0 : w_acc;
      if (w_acc) begin
        r_exact <= PROD_W'(a) * PROD_W'(b);
        r_apprx <= apprx;
      end
    end
  end

  mul_err_diff #(
    .PROD_W (PROD_W)
  ) u_diff (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_valid (r_v1),
    .i_exact (r_exact),
    .i_apprx (r_apprx),
    .o_valid (w_v2),
    .o_diff  (w_diff),
    .o_absd  (w_absd),
    .o_neq   (w_neq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= '0;
      r_sed  <= '0;
      r_saed <= '0;
      r_max  <= '0;
    end else if (w_clr) begin
      r_err  <= '0;
      r_sed  <= '0;
      r_saed <= '0;
      r_max  <= '0;
    end else if (w_v2) begin
      r_err  <= ACC_W'(sat_add_u(
                  64'(r_err), 64'(w_neq), ACC_W));
      r_sed  <= ACC_W'(sat_add_s(
                  64'($signed(r_sed)), 64'(w_diff), ACC_W));
      r_saed <= ACC_W'(sat_add_u(
                  64'(r_saed), 64'(w_absd), ACC_W));
      if (w_absd > r_max) r_max <= w_absd;
    end
  end

  assign sample_cnt = r_cnt;
  assign err_cnt    = r_err;
  assign sum_ed     = r_sed;
  assign sum_aed    = r_saed;
  assign max_aed    = r_max;

endmodule

// File: doc/mul8_err_accumulator.md
# mul8_err_accumulator

Hardware error-metric accumulator that sits directly downstream of an 8-bit approximate multiplier (e.g. mul8_061). Each sample takes the operands and the approximate product, forms the exact product internally, and accumulates error count, signed and absolute error distance, and maximum absolute error over a programmed run of samples. Software or the bench derives ER, MED and MNED from the frozen totals; no division is done in hardware.

## Interface
- IN_W, 8, operand width
- PROD_W, 16, product width (2*IN_W)
- N_SAMPLES, 10000, samples per run (>= 1)
- ACC_W, 32, width of every accumulator and counter
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; honoured only in IDLE or DONE
- in_valid  in  1  sample present on a/b/apprx
- in_ready  out  1  sample accepted when in_valid & in_ready at a clock edge
- a, b  in  IN_W each  unsigned operands fed to the multiplier
- apprx  in  PROD_W  approximate product for a, b
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; results stable
- sample_cnt  out  ACC_W  samples accepted this run
- err_cnt  out  ACC_W  samples with exact != apprx
- sum_ed  out  ACC_W  signed sum of (exact - apprx), two's complement
- sum_aed  out  ACC_W  sum of |exact - apprx|
- max_aed  out  PROD_W  largest |exact - apprx| seen

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset -> IDLE; all outputs 0, in_ready 0.
- IDLE/DONE + start: clear all accumulators, counters and pipeline valids; go RUN.
- RUN: in_ready = 1 while sample_cnt < N_SAMPLES. Each accept increments sample_cnt. Accept that makes sample_cnt == N_SAMPLES -> DRAIN at that same edge; in_ready drops.
- DRAIN: in_ready 0; wait until both pipeline valid bits clear; then DONE.
- DONE: done = 1, outputs frozen until next start. start in RUN/DRAIN ignored.
- Stage 1: exact = a*b (PROD_W unsigned), register exact, apprx, v1.
- Stage 2 (sub-module): diff = exact - apprx as PROD_W+1 signed; absd = |diff|; neq = (diff != 0); register with v2.
- Accumulate on v2: err_cnt += neq; sum_ed += sign-extended diff; sum_aed += absd; max_aed = max(max_aed, absd). Equal products add 0 to sum_ed (no stale carry-over).
- sum_aed, err_cnt saturate at 2^ACC_W-1; sum_ed saturates at signed min/max. Default parameters cannot saturate (max 10000*65025 < 2^32).
- in_valid while in_ready = 0: sample ignored, not counted.

## Timing
- Sample accepted at edge E: stage 1 loaded at E, stage 2 at E+1, accumulators include it after E+2.
- Throughput 1 sample/clock; no back-pressure inside the pipeline.
- Final sample at edge E: DRAIN from E, DONE and done=1 after E+2 (same edge as final accumulate).
- start at edge S: busy=1, in_ready=1 (N_SAMPLES>0), outputs zero after S.
- rst_n low at any time: immediately IDLE, all registers 0, partial run discarded.

## Structure
- Package mul_err_pkg: state enum (IDLE, RUN, DRAIN, DONE), default IN_W/PROD_W/ACC_W constants, saturating-add helper function.
- Sub-module mul_err_diff: stage-2 register computing diff, absd, neq from exact/apprx with valid.
- Top holds FSM, sample counter, stage-1 multiplier register, accumulators.

## Test plan
- N_SAMPLES=4, apprx always a*b (a=3,b=5,apprx=15 etc.) -> err_cnt 0, sum_ed 0, sum_aed 0, max_aed 0, done after last accept +2 edges.
- N_SAMPLES=3, samples (255,255,65024),(10,10,105),(2,3,6) -> sample_cnt 3, err_cnt 2, sum_ed -4, sum_aed 6, max_aed 5.
- N_SAMPLES=2 with in_valid gaps and in_valid held after 2nd accept -> in_ready 0 after 2nd accept, extra samples not counted, sample_cnt 2.
- start asserted during RUN -> ignored; start in DONE -> outputs zeroed, new run begins, done drops.
- rst_n pulsed low mid-RUN after 5 of 10 samples -> all outputs 0 asynchronously, state IDLE, busy 0.
- ACC_W=8, N_SAMPLES=4, each |diff|=100 -> sum_aed saturates at 255, err_cnt 4.
